// File: rtl/fifo_wr_demux4.sv
// Write-side steering, pointers and occupancy flags for a 4-entry FIFO.
// Optional sticky overflow/underflow flag enabled by defining FIFO_WR_OVF_FLAG_EN.
module fifo_wr_demux4 #(
  parameter int WIDTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [1:0]       rd_sel,
  output logic [2:0]       count,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             ovf
);

  logic [WIDTH-1:0] slot [4];
  logic [1:0]       wr_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [2:0]       count_nxt;

  // full is sampled before the read retires, so a full FIFO rejects a same-cycle write
  assign wr_acc    = wr_en & ~full;
  assign rd_acc    = rd_en & ~empty;
  assign count_nxt = count + {2'b00, wr_acc} - {2'b00, rd_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) slot[i] <= '0;
      wr_ptr <= 2'd0;
    end else if (wr_acc) begin
      slot[wr_ptr] <= din;
      wr_ptr       <= wr_ptr + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel <= 2'd0;
    end else if (rd_acc) begin
      rd_sel <= rd_sel + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 3'd0;
      full  <= 1'b0;
      empty <= 1'b1;
      afull <= 1'b0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == 3'd4);
      empty <= (count_nxt == 3'd0);
      afull <= (count_nxt >= 3'(AFULL_TH));
    end
  end

  assign q0 = slot[0];
  assign q1 = slot[1];
  assign q2 = slot[2];
  assign q3 = slot[3];

`ifdef FIFO_WR_OVF_FLAG_EN
  // Sticky until reset: records any dropped write or attempted read of an empty FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if ((wr_en & full) | (rd_en & empty)) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_demux4.sv
// Directed self-checking bench for fifo_wr_demux4 (expects ovf behaviour per FIFO_WR_OVF_FLAG_EN).
module tb_fifo_wr_demux4;

`ifdef FIFO_WR_OVF_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] din;
  logic       rd_en;
  logic [3:0] q0, q1, q2, q3;
  logic [1:0] rd_sel;
  logic [2:0] count;
  logic       full, empty, afull, ovf;

  int checks = 0;
  int errors = 0;

  fifo_wr_demux4 #(.WIDTH(4), .AFULL_TH(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .rd_sel(rd_sel), .count(count),
    .full(full), .empty(empty), .afull(afull), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic w, input logic [3:0] d, input logic r);
    wr_en = w; din = d; rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; din = 4'h0;
  endtask

  function automatic logic [3:0] head();
    case (rd_sel)
      2'd0: return q0;
      2'd1: return q1;
      2'd2: return q2;
      default: return q3;
    endcase
  endfunction

  logic [3:0] model_q[$];
  logic [3:0] exp_head;
  logic [3:0] d;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 4'h0;
    #12;
    chk("rst_q0", q0, 8'h0);
    chk("rst_rd_sel", rd_sel, 8'd0);
    chk("rst_count", count, 8'd0);
    chk("rst_empty", empty, 8'd1);
    chk("rst_full", full, 8'd0);
    chk("rst_afull", afull, 8'd0);
    chk("rst_ovf", ovf, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // fill
    cyc(1, 4'hA, 0);
    chk("fill1_count", count, 8'd1);
    chk("fill1_empty", empty, 8'd0);
    chk("fill1_afull", afull, 8'd0);
    cyc(1, 4'hB, 0);
    chk("fill2_count", count, 8'd2);
    cyc(1, 4'hC, 0);
    chk("fill3_count", count, 8'd3);
    chk("fill3_afull", afull, 8'd1);
    chk("fill3_full", full, 8'd0);
    cyc(1, 4'hD, 0);
    chk("fill4_count", count, 8'd4);
    chk("fill4_full", full, 8'd1);
    chk("fill_q0", q0, 8'hA);
    chk("fill_q1", q1, 8'hB);
    chk("fill_q2", q2, 8'hC);
    chk("fill_q3", q3, 8'hD);
    cyc(1, 4'hE, 0);
    chk("rej_q0", q0, 8'hA);
    chk("rej_count", count, 8'd4);
    chk("ovf_after_drop", ovf, {7'd0, OVF_EN});

    // full with simultaneous write and read
    cyc(1, 4'hF, 1);
    chk("simfull_count", count, 8'd3);
    chk("simfull_rd_sel", rd_sel, 8'd1);
    chk("simfull_full", full, 8'd0);
    chk("simfull_afull", afull, 8'd1);
    chk("simfull_q0", q0, 8'hA);

    cyc(0, 4'h0, 1);
    chk("drain_rd_sel", rd_sel, 8'd2);
    chk("drain_count", count, 8'd2);
    chk("drain_afull", afull, 8'd0);

    // wrap
    cyc(1, 4'h5, 0);
    cyc(1, 4'h6, 0);
    chk("wrap_q0", q0, 8'h5);
    chk("wrap_q1", q1, 8'h6);
    chk("wrap_full", full, 8'd1);
    chk("rd0_sel", rd_sel, 8'd2);
    chk("rd0_data", head(), 8'hC);
    cyc(0, 4'h0, 1);
    chk("rd1_sel", rd_sel, 8'd3);
    chk("rd1_data", head(), 8'hD);
    cyc(0, 4'h0, 1);
    chk("rd2_sel", rd_sel, 8'd0);
    chk("rd2_data", head(), 8'h5);
    cyc(0, 4'h0, 1);
    chk("rd3_sel", rd_sel, 8'd1);
    chk("rd3_data", head(), 8'h6);
    cyc(0, 4'h0, 1);
    chk("drained_empty", empty, 8'd1);
    chk("drained_count", count, 8'd0);
    chk("drained_rd_sel", rd_sel, 8'd2);

    // empty with simultaneous write and read
    cyc(1, 4'h7, 1);
    chk("simempty_count", count, 8'd1);
    chk("simempty_rd_sel", rd_sel, 8'd2);
    chk("simempty_q2", q2, 8'h7);
    cyc(1, 4'h8, 0);
    chk("pre_stream_count", count, 8'd2);

    // steady stream
    model_q.push_back(4'h7);
    model_q.push_back(4'h8);
    for (int i = 0; i < 20; i++) begin
      d = 4'(i + 9);
      exp_head = model_q.pop_front();
      chk("stream_head", head(), {4'h0, exp_head});
      cyc(1, d, 1);
      model_q.push_back(d);
      chk("stream_count", count, 8'd2);
    end
    chk("ovf_sticky", ovf, {7'd0, OVF_EN});

    // async reset mid-stream, no clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 8'd0);
    chk("mid_rst_empty", empty, 8'd1);
    chk("mid_rst_rd_sel", rd_sel, 8'd0);
    chk("mid_rst_q3", q3, 8'h0);
    chk("mid_rst_ovf", ovf, 8'd0);
    @(posedge clk); #1;
    chk("hold_rst_count", count, 8'd0);
    rst_n = 1'b1;

    // read on empty
    cyc(0, 4'h0, 1);
    chk("underflow_rd_sel", rd_sel, 8'd0);
    chk("underflow_count", count, 8'd0);
    chk("underflow_ovf", ovf, {7'd0, OVF_EN});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
